// File: rtl/mem_copy_engine.sv
// Block COPY / FILL engine driving a single-port 32 x WORDSIZE data_memory.
// It also accumulates an XOR signature of every word written by a command.
module mem_copy_engine #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [4:0]          src_addr,
    input  logic [4:0]          dst_addr,
    input  logic [5:0]          length,
    input  logic [WORDSIZE-1:0] fill_value,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [5:0]          words_done,
    output logic [WORDSIZE-1:0] xor_signature,
    output logic [4:0]          mem_addr,
    output logic [WORDSIZE-1:0] mem_data_input,
    output logic                mem_write_enable,
    output logic                mem_read,
    input  logic [WORDSIZE-1:0] mem_data_output
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic       OP_COPY = 1'b0;
    localparam logic [5:0] MAX_LEN = 6'(SIZE);

    state_t              r_state;
    logic                r_op;
    logic [4:0]          r_src;
    logic [4:0]          r_dst;
    logic [5:0]          r_len;
    logic [5:0]          r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [5:0]          r_words_done;
    logic [WORDSIZE-1:0] r_xor;
    logic [4:0]          r_mem_addr;
    logic [WORDSIZE-1:0] r_mem_data_input;
    logic                r_mem_write_enable;
    logic                r_mem_read;

    logic [5:0] w_idx_next;
    logic [4:0] w_dst_addr;
    logic [4:0] w_src_next_addr;
    logic [4:0] w_dst_next_addr;
    logic       w_last;

    // 5-bit sums give the modulo-32 address wrap for free.
    assign w_idx_next      = r_idx + 6'd1;
    assign w_dst_addr      = r_dst + r_idx[4:0];
    assign w_src_next_addr = r_src + w_idx_next[4:0];
    assign w_dst_next_addr = r_dst + w_idx_next[4:0];
    assign w_last          = (w_idx_next == r_len);

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign words_done       = r_words_done;
    assign xor_signature    = r_xor;
    assign mem_addr         = r_mem_addr;
    assign mem_data_input   = r_mem_data_input;
    assign mem_write_enable = r_mem_write_enable;
    assign mem_read         = r_mem_read;

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_op               <= 1'b0;
            r_src              <= '0;
            r_dst              <= '0;
            r_len              <= '0;
            r_idx              <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
            r_words_done       <= '0;
            r_xor              <= '0;
            r_mem_addr         <= '0;
            r_mem_data_input   <= '0;
            r_mem_write_enable <= 1'b0;
            r_mem_read         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op         <= op;
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_len        <= length;
                        r_idx        <= '0;
                        r_words_done <= '0;
                        r_xor        <= '0;
                        r_error      <= 1'b0;
                        if (length > MAX_LEN) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (length == 6'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (op == OP_COPY) begin
                            r_busy     <= 1'b1;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= src_addr;
                            r_state    <= S_READ;
                        end else begin
                            r_busy             <= 1'b1;
                            r_mem_write_enable <= 1'b1;
                            r_mem_addr         <= dst_addr;
                            r_mem_data_input   <= fill_value;
                            r_state            <= S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    // The data input register doubles as the word buffer.
                    r_mem_read         <= 1'b0;
                    r_mem_write_enable <= 1'b1;
                    r_mem_addr         <= w_dst_addr;
                    r_mem_data_input   <= mem_data_output;
                    r_state            <= S_WRITE;
                end
                S_WRITE: begin
                    r_words_done <= r_words_done + 6'd1;
                    r_xor        <= r_xor ^ r_mem_data_input;
                    r_idx        <= w_idx_next;
                    if (w_last) begin
                        r_busy             <= 1'b0;
                        r_done             <= 1'b1;
                        r_mem_write_enable <= 1'b0;
                        r_mem_data_input   <= '0;
                        r_mem_addr         <= '0;
                        r_state            <= S_DONE;
                    end else if (r_op == OP_COPY) begin
                        r_mem_write_enable <= 1'b0;
                        r_mem_data_input   <= '0;
                        r_mem_read         <= 1'b1;
                        r_mem_addr         <= w_src_next_addr;
                        r_state            <= S_READ;
                    end else begin
                        r_mem_addr <= w_dst_next_addr;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural memory and a
// sequential word-by-word reference model of COPY/FILL.
module tb_mem_copy_engine;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [4:0]   src_addr = '0;
    logic [4:0]   dst_addr = '0;
    logic [5:0]   length = '0;
    logic [W-1:0] fill_value = '0;
    logic         busy;
    logic         done;
    logic         error;
    logic [5:0]   words_done;
    logic [W-1:0] xor_signature;
    logic [4:0]   mem_addr;
    logic [W-1:0] mem_data_input;
    logic         mem_write_enable;
    logic         mem_read;
    logic [W-1:0] mem_data_output;

    logic [W-1:0] mem     [32];
    logic [W-1:0] exp_mem [32];
    logic         tb_we = 1'b0;
    logic [4:0]   tb_addr = '0;
    logic [W-1:0] tb_din = '0;

    int errors = 0;
    int checks = 0;
    int rd_addrs[$];
    int wr_addrs[$];
    int wr_cycle[$];
    int done_k;
    int done_cnt;
    int busy_cnt;

    mem_copy_engine #(.WORDSIZE(W), .SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done), .error(error),
        .words_done(words_done), .xor_signature(xor_signature),
        .mem_addr(mem_addr), .mem_data_input(mem_data_input),
        .mem_write_enable(mem_write_enable), .mem_read(mem_read),
        .mem_data_output(mem_data_output)
    );

    always #5 clk = ~clk;

    // data_memory: combinational read, write on rising edge; bench port used for preload.
    assign mem_data_output = mem[mem_addr];
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_din;
        else if (mem_write_enable) mem[mem_addr] <= mem_data_input;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (mem_read && mem_write_enable) begin
                errors++;
                $display("FAIL proto_rd_wr: read=%0b write_enable=%0b, required not both 1", mem_read, mem_write_enable);
            end
            checks++;
            if (!mem_write_enable && mem_data_input !== '0) begin
                errors++;
                $display("FAIL proto_din_idle: data_input=%h with write_enable=0, required 0", mem_data_input);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic poke(input int a, input logic [W-1:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a[4:0]; tb_din = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) poke(i, {$urandom, $urandom});
    endtask

    // Reference: sequential ascending word transfer with plain modulo-32 indexing.
    task automatic model_apply(input logic o, input int s, input int d, input int l,
                               input logic [W-1:0] f, output int wd,
                               output logic [W-1:0] x, output logic e);
        logic [W-1:0] w;
        wd = 0; x = '0; e = (l > 32);
        if (!e) begin
            for (int i = 0; i < l; i++) begin
                w = o ? f : exp_mem[(s + i) % 32];
                exp_mem[(d + i) % 32] = w;
                x ^= w;
                wd++;
            end
        end
    endtask

    function automatic int exp_done_k(input logic o, input int l);
        if (l == 0 || l > 32) return 1;
        return (o ? l : 2 * l) + 1;
    endfunction

    function automatic int mem_mismatches();
        int n = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    function automatic logic all_outputs_zero();
        return ({busy, done, error, words_done, xor_signature, mem_addr,
                 mem_data_input, mem_write_enable, mem_read} === '0);
    endfunction

    // Issues one command and records activity per cycle, k = cycles after the accepting edge.
    task automatic run_cmd(input logic o, input int s, input int d, input int l,
                           input logic [W-1:0] f, input bit hold);
        rd_addrs.delete(); wr_addrs.delete(); wr_cycle.delete();
        done_k = 0; done_cnt = 0; busy_cnt = 0;
        @(negedge clk);
        op = o; src_addr = s[4:0]; dst_addr = d[4:0]; length = l[5:0];
        fill_value = f; start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mem_read) rd_addrs.push_back(int'(mem_addr));
            if (mem_write_enable) begin
                wr_addrs.push_back(int'(mem_addr));
                wr_cycle.push_back(k);
            end
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
                start = 1'b0;
            end
            if (done_k != 0 && k >= done_k + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (!all_outputs_zero()) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b we=%0b rd=%0b addr=%0d, required all 0",
                     busy, done, mem_write_enable, mem_read, mem_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (!all_outputs_zero()) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b words_done=%0d, required all 0",
                     busy, done, words_done);
        end
    endtask

    task automatic test_copy_basic();
        int wd; logic [W-1:0] x; logic e;
        init_mem();
        poke(5, 64'h0000_0000_0005_e3a7);
        poke(14, 64'h0000_0000_001f_13a2);
        model_apply(1'b0, 5, 20, 1, '0, wd, x, e);
        run_cmd(1'b0, 5, 20, 1, '0, 1'b0);
        checks++;
        if (done_k !== 3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL copy1_latency: done at k=%0d count=%0d, required k=3 count=1", done_k, done_cnt);
        end
        checks++;
        if (rd_addrs.size() != 1 || wr_addrs.size() != 1 ||
            (rd_addrs.size() == 1 && rd_addrs[0] != 5) || (wr_addrs.size() == 1 && wr_addrs[0] != 20)) begin
            errors++;
            $display("FAIL copy1_addrs: reads=%0d writes=%0d, required one read at 5, one write at 20",
                     rd_addrs.size(), wr_addrs.size());
        end
        checks++;
        if (mem[20] !== 64'h5e3a7 || words_done !== 6'd1 || xor_signature !== 64'h5e3a7 || error !== 1'b0) begin
            errors++;
            $display("FAIL copy1_result: mem20=%h wd=%0d sig=%h err=%0b, required 5e3a7/1/5e3a7/0",
                     mem[20], words_done, xor_signature, error);
        end
        checks++;
        if (mem_mismatches() != 0) begin
            errors++;
            $display("FAIL copy1_memory: %0d words differ, required 0", mem_mismatches());
        end
    endtask

    task automatic test_fill_wrap();
        int wd; logic [W-1:0] x; logic e; logic [W-1:0] m2; bit ok;
        m2 = exp_mem[2];
        model_apply(1'b1, 0, 30, 4, 64'hDEAD_BEEF_0000_0001, wd, x, e);
        run_cmd(1'b1, 0, 30, 4, 64'hDEAD_BEEF_0000_0001, 1'b0);
        ok = (wr_addrs.size() == 4) && (rd_addrs.size() == 0);
        for (int i = 0; i < wr_addrs.size() && ok; i++)
            if (wr_addrs[i] != (30 + i) % 32 || wr_cycle[i] != i + 1) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fill_wrap_addrs: writes=%0d reads=%0d, required 30,31,0,1 on cycles 1..4 and no reads",
                     wr_addrs.size(), rd_addrs.size());
        end
        checks++;
        if (done_k !== 5) begin
            errors++;
            $display("FAIL fill_latency: done at k=%0d, required 5", done_k);
        end
        checks++;
        if (xor_signature !== '0 || words_done !== 6'd4 || mem[2] !== m2) begin
            errors++;
            $display("FAIL fill_result: sig=%h wd=%0d mem2=%h, required 0/4/%h", xor_signature, words_done, mem[2], m2);
        end
        checks++;
        if (mem_mismatches() != 0) begin
            errors++;
            $display("FAIL fill_memory: %0d words differ, required 0", mem_mismatches());
        end
    endtask

    task automatic test_copy_overlap();
        int wd; logic [W-1:0] x; logic e;
        for (int i = 0; i < 4; i++) poke(i, W'(i + 1));
        model_apply(1'b0, 0, 1, 3, '0, wd, x, e);
        run_cmd(1'b0, 0, 1, 3, '0, 1'b0);
        checks++;
        if (mem[0] !== 64'd1 || mem[1] !== 64'd1 || mem[2] !== 64'd1 || mem[3] !== 64'd1) begin
            errors++;
            $display("FAIL overlap_words: mem0..3=%0d,%0d,%0d,%0d, required 1,1,1,1", mem[0], mem[1], mem[2], mem[3]);
        end
        checks++;
        if (xor_signature !== 64'd1 || words_done !== 6'd3 || done_k !== 7) begin
            errors++;
            $display("FAIL overlap_status: sig=%h wd=%0d done_k=%0d, required 1/3/7", xor_signature, words_done, done_k);
        end
    endtask

    task automatic test_zero_and_error();
        run_cmd(1'b0, 3, 9, 0, '0, 1'b0);
        checks++;
        if (done_k !== 1 || rd_addrs.size() != 0 || wr_addrs.size() != 0 ||
            error !== 1'b0 || words_done !== 6'd0 || xor_signature !== '0) begin
            errors++;
            $display("FAIL len0: done_k=%0d rd=%0d wr=%0d err=%0b wd=%0d, required 1/0/0/0/0",
                     done_k, rd_addrs.size(), wr_addrs.size(), error, words_done);
        end
        run_cmd(1'b1, 3, 9, 40, 64'h1234, 1'b0);
        checks++;
        if (done_k !== 1 || rd_addrs.size() != 0 || wr_addrs.size() != 0 || error !== 1'b1) begin
            errors++;
            $display("FAIL len40: done_k=%0d rd=%0d wr=%0d err=%0b, required 1/0/0/1",
                     done_k, rd_addrs.size(), wr_addrs.size(), error);
        end
        checks++;
        if (mem_mismatches() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len40_side_effects: %0d words differ busy=%0b, required 0/0", mem_mismatches(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int wd; logic [W-1:0] x; logic e;
        model_apply(1'b0, 8, 16, 4, '0, wd, x, e);
        run_cmd(1'b0, 8, 16, 4, '0, 1'b1);
        checks++;
        if (busy_cnt !== 8 || done_cnt !== 1 || rd_addrs.size() != 4 || wr_addrs.size() != 4) begin
            errors++;
            $display("FAIL held_start: busy=%0d done=%0d rd=%0d wr=%0d, required 8/1/4/4",
                     busy_cnt, done_cnt, rd_addrs.size(), wr_addrs.size());
        end
        checks++;
        if (mem_mismatches() != 0 || words_done !== 6'd4 || xor_signature !== x) begin
            errors++;
            $display("FAIL held_start_result: diff=%0d wd=%0d sig=%h, required 0/4/%h",
                     mem_mismatches(), words_done, xor_signature, x);
        end
    endtask

    task automatic test_async_abort();
        logic [W-1:0] f; int wd; logic [W-1:0] x; logic e;
        f = {$urandom, $urandom};
        @(negedge clk);
        op = 1'b1; dst_addr = 5'd10; length = 6'd8; fill_value = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (mem_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: write_enable=%0b before reset, required 1", mem_write_enable);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!all_outputs_zero()) begin
            errors++;
            $display("FAIL abort_outputs: we=%0b busy=%0b wd=%0d, required all 0 without a clock edge",
                     mem_write_enable, busy, words_done);
        end
        for (int i = 0; i < 3; i++) exp_mem[10 + i] = f;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_mismatches() != 0) begin
            errors++;
            $display("FAIL abort_memory: %0d words differ, required 3 written and words 4..8 untouched",
                     mem_mismatches());
        end
        rst_n = 1'b1;
        model_apply(1'b1, 0, 25, 2, f ^ 64'h5555, wd, x, e);
        run_cmd(1'b1, 0, 25, 2, f ^ 64'h5555, 1'b0);
        checks++;
        if (done_k !== 3 || words_done !== 6'd2 || mem_mismatches() != 0) begin
            errors++;
            $display("FAIL abort_recover: done_k=%0d wd=%0d diff=%0d, required 3/2/0",
                     done_k, words_done, mem_mismatches());
        end
    endtask

    task automatic test_random();
        logic o; int s, d, l; logic [W-1:0] f; int wd; logic [W-1:0] x; logic e;
        init_mem();
        for (int n = 0; n < 25; n++) begin
            o = 1'($urandom_range(0, 1));
            s = $urandom_range(0, 31);
            d = $urandom_range(0, 31);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 40) : $urandom_range(0, 32);
            f = {$urandom, $urandom};
            model_apply(o, s, d, l, f, wd, x, e);
            run_cmd(o, s, d, l, f, 1'b0);
            checks++;
            if (done_k !== exp_done_k(o, l) || done_cnt !== 1) begin
                errors++;
                $display("FAIL rand%0d_latency: op=%0b len=%0d done_k=%0d cnt=%0d, required %0d/1",
                         n, o, l, done_k, done_cnt, exp_done_k(o, l));
            end
            checks++;
            if (int'(words_done) != wd || xor_signature !== x || error !== e) begin
                errors++;
                $display("FAIL rand%0d_status: wd=%0d sig=%h err=%0b, required %0d/%h/%0b",
                         n, words_done, xor_signature, error, wd, x, e);
            end
            checks++;
            if (wr_addrs.size() != wd || rd_addrs.size() != (o ? 0 : wd)) begin
                errors++;
                $display("FAIL rand%0d_accesses: wr=%0d rd=%0d, required %0d/%0d",
                         n, wr_addrs.size(), rd_addrs.size(), wd, o ? 0 : wd);
            end
            checks++;
            if (mem_mismatches() != 0) begin
                errors++;
                $display("FAIL rand%0d_memory: %0d words differ, required 0", n, mem_mismatches());
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy_basic();
        test_fill_wrap();
        test_copy_overlap();
        test_zero_and_error();
        test_back_to_back();
        test_async_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
